alu_selftest: RTL

Synthesizable self-checking sequencer that sits directly upstream of the ALU. It fetches test vectors {aluop, a, b, expected result} from a synchronous vector ROM and drives the ALU operand and opcode inputs. It then captures the ALU `result`/`zero` outputs, compares them against the expected values, and reports pass/fail, error count and the first failing address on the board. It lets the team verify the ALU on the FPGA, not only in simulation.

---
 rtl/alu_selftest.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_selftest.sv
// On-board ALU self-test sequencer: walks a synchronous vector ROM, drives the ALU,
// and compares each result/zero pair against the stored expectation.
module alu_selftest #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  END_OP = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [99:0]       vec_data,
  output logic [3:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [7:0]        vec_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_APPLY, S_SETTLE, S_CHECK, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
  localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE - 1);

  state_t            state_q;
  logic [3:0]        settle_q;
  logic [31:0]       exp_q;
  logic [ADDR_W-1:0] vec_addr_q;
  logic [3:0]        alu_op_q;
  logic [31:0]       alu_a_q;
  logic [31:0]       alu_b_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [7:0]        err_cnt_q;
  logic [7:0]        vec_cnt_q;
  logic [ADDR_W-1:0] first_err_addr_q;
  logic              first_err_valid_q;

  logic              mismatch;
  logic [7:0]        err_cnt_d;
  logic [7:0]        vec_cnt_d;

  // The zero flag is checked independently so a stuck flag is caught even when the result is right.
  assign mismatch = (alu_result != exp_q) || (alu_zero != (exp_q == 32'h0));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    vec_cnt_d = (vec_cnt_q == 8'hFF) ? vec_cnt_q : vec_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      settle_q          <= '0;
      exp_q             <= '0;
      vec_addr_q        <= '0;
      alu_op_q          <= '0;
      alu_a_q           <= '0;
      alu_b_q           <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_cnt_q         <= '0;
      vec_cnt_q         <= '0;
      first_err_addr_q  <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q           <= S_FETCH;
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            vec_addr_q        <= '0;
            err_cnt_q         <= '0;
            vec_cnt_q         <= '0;
            first_err_addr_q  <= '0;
            first_err_valid_q <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_APPLY;
        S_APPLY: begin
          if (vec_data[99:96] == END_OP) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_q == 8'd0) && (vec_cnt_q != 8'd0);
          end else begin
            alu_op_q <= vec_data[99:96];
            alu_a_q  <= vec_data[95:64];
            alu_b_q  <= vec_data[63:32];
            exp_q    <= vec_data[31:0];
            settle_q <= SETTLE_LOAD;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_q == 4'd0) state_q <= S_CHECK;
          else                  settle_q <= settle_q - 4'd1;
        end
        S_CHECK: begin
          err_cnt_q <= err_cnt_d;
          vec_cnt_q <= vec_cnt_d;
          if (mismatch && !first_err_valid_q) begin
            first_err_addr_q  <= vec_addr_q;
            first_err_valid_q <= 1'b1;
          end
          // A full ROM ends the run rather than wrapping back to address 0.
          if (vec_addr_q == LAST_ADDR) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 8'd0) && (vec_cnt_d != 8'd0);
          end else begin
            vec_addr_q <= vec_addr_q + 1'b1;
            state_q    <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_addr        = vec_addr_q;
  assign alu_op          = alu_op_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign vec_cnt         = vec_cnt_q;
  assign first_err_addr  = first_err_addr_q;
  assign first_err_valid = first_err_valid_q;

endmodule
